// File: rtl/cdc_bridge_pkg.sv
// Shared types and default widths for the clock-domain request/response bridge.
package cdc_bridge_pkg;

  localparam int unsigned REQ_WIDTH_DEF   = 32;
  localparam int unsigned RSP_WIDTH_DEF   = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    I_IDLE,
    I_WAIT,
    I_RSP
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_RSP
  } out_state_t;

endpackage

// File: rtl/cdc_req_resp_bridge_if.sv
// Handshake bundle for both sides of the bridge: initiator (clk_in) and responder (clk_out).
interface cdc_req_resp_bridge_if
  import cdc_bridge_pkg::*;
#(
  parameter int unsigned REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int unsigned RSP_WIDTH = RSP_WIDTH_DEF
) ();

  // clk_in side
  logic                 req_ready;
  logic                 req_valid;
  logic [REQ_WIDTH-1:0] req_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RSP_WIDTH-1:0] rsp_data;

  // clk_out side
  logic                 out_req_valid;
  logic                 out_req_ready;
  logic [REQ_WIDTH-1:0] out_req_data;
  logic                 out_rsp_valid;
  logic                 out_rsp_ready;
  logic [RSP_WIDTH-1:0] out_rsp_data;

  // Bridge view
  modport slave (
    input  req_valid, req_data, rsp_ready,
    input  out_req_ready, out_rsp_valid, out_rsp_data,
    output req_ready, rsp_valid, rsp_data,
    output out_req_valid, out_req_data, out_rsp_ready
  );

  // Initiator + responder view
  modport master (
    output req_valid, req_data, rsp_ready,
    output out_req_ready, out_rsp_valid, out_rsp_data,
    input  req_ready, rsp_valid, rsp_data,
    input  out_req_valid, out_req_data, out_rsp_ready
  );

endinterface

// File: rtl/reset_sync.sv
// Reset synchroniser: asynchronous assert, synchronous deassert into clk.
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_in,
  output logic rst_out
);

  logic [STAGES-1:0] chain;

  // Shift zeros in once rst_in drops; any assert fills the chain with ones at once
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) chain <= '1;
    else        chain <= {chain[STAGES-2:0], 1'b0};
  end

  assign rst_out = chain[STAGES-1];

endmodule

// File: rtl/toggle_sync.sv
// Toggle synchroniser: carries a level toggle into clk and emits a one-cycle pulse per flip.
module toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic pulse_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  // Synchroniser chain plus registered copy of its last stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tgl};
      last <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse_c = sync[SYNC_STAGES-1] ^ last;

endmodule

// File: rtl/cdc_req_resp_bridge.sv
// Single-outstanding request/response bridge between clk_in and clk_out.
// Payloads sit in hold registers that only change while the other side is not sampling;
// only the toggles pass through synchronisers.
module cdc_req_resp_bridge
  import cdc_bridge_pkg::*;
#(
  parameter int unsigned REQ_WIDTH   = REQ_WIDTH_DEF,
  parameter int unsigned RSP_WIDTH   = RSP_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk_in,
  input  logic                  clk_out,
  input  logic                  reset_in,
  cdc_req_resp_bridge_if.slave  bus
);

  logic                 reset_out;
  logic                 req_tgl;
  logic                 rsp_tgl;
  logic                 req_pulse_c;
  logic                 rsp_pulse_c;
  logic [REQ_WIDTH-1:0] req_hold;
  logic [RSP_WIDTH-1:0] rsp_hold;

  in_state_t  in_state, in_state_nx;
  out_state_t out_state, out_state_nx;
  logic       req_take_c, rsp_load_c;
  logic       out_load_c, out_take_c;

  reset_sync #(.STAGES(SYNC_STAGES)) u_reset_sync (
    .clk     (clk_out),
    .rst_in  (reset_in),
    .rst_out (reset_out)
  );

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk     (clk_out),
    .rst     (reset_out),
    .tgl     (req_tgl),
    .pulse_c (req_pulse_c)
  );

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rsp_sync (
    .clk     (clk_in),
    .rst     (reset_in),
    .tgl     (rsp_tgl),
    .pulse_c (rsp_pulse_c)
  );

  // clk_in state register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) in_state <= I_IDLE;
    else          in_state <= in_state_nx;
  end

  // clk_in next state; a request is taken only while req_ready is actually shown
  always_comb begin
    in_state_nx = in_state;
    req_take_c  = 1'b0;
    rsp_load_c  = 1'b0;
    case (in_state)
      I_IDLE: if (bus.req_valid && bus.req_ready) begin
        req_take_c  = 1'b1;
        in_state_nx = I_WAIT;
      end
      I_WAIT: if (rsp_pulse_c) begin
        rsp_load_c  = 1'b1;
        in_state_nx = I_RSP;
      end
      I_RSP: if (bus.rsp_ready) in_state_nx = I_IDLE;
      default: in_state_nx = I_IDLE;
    endcase
  end

  // clk_in datapath and registered handshake outputs
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      req_hold      <= '0;
      req_tgl       <= 1'b0;
      bus.rsp_data  <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
    end else begin
      if (req_take_c) begin
        req_hold <= bus.req_data;
        req_tgl  <= ~req_tgl;
      end
      if (rsp_load_c) bus.rsp_data <= rsp_hold;
      bus.req_ready <= (in_state_nx == I_IDLE);
      bus.rsp_valid <= (in_state_nx == I_RSP);
    end
  end

  // clk_out state register
  always_ff @(posedge clk_out or posedge reset_out) begin
    if (reset_out) out_state <= O_IDLE;
    else           out_state <= out_state_nx;
  end

  // clk_out next state; replies offered outside O_RSP are ignored
  always_comb begin
    out_state_nx = out_state;
    out_load_c   = 1'b0;
    out_take_c   = 1'b0;
    case (out_state)
      O_IDLE: if (req_pulse_c) begin
        out_load_c   = 1'b1;
        out_state_nx = O_REQ;
      end
      O_REQ: if (bus.out_req_ready) out_state_nx = O_RSP;
      O_RSP: if (bus.out_rsp_valid) begin
        out_take_c   = 1'b1;
        out_state_nx = O_IDLE;
      end
      default: out_state_nx = O_IDLE;
    endcase
  end

  // clk_out datapath and registered handshake outputs
  always_ff @(posedge clk_out or posedge reset_out) begin
    if (reset_out) begin
      rsp_hold          <= '0;
      rsp_tgl           <= 1'b0;
      bus.out_req_data  <= '0;
      bus.out_req_valid <= 1'b0;
      bus.out_rsp_ready <= 1'b0;
    end else begin
      if (out_load_c) bus.out_req_data <= req_hold;
      if (out_take_c) begin
        rsp_hold <= bus.out_rsp_data;
        rsp_tgl  <= ~rsp_tgl;
      end
      bus.out_req_valid <= (out_state_nx == O_REQ);
      bus.out_rsp_ready <= (out_state_nx == O_RSP);
    end
  end

endmodule

// File: tb/tb_cdc_req_resp_bridge.sv
// Directed and table-driven bench for cdc_req_resp_bridge.
module tb_cdc_req_resp_bridge;

  logic clk_in, clk_out, reset_in;
  int   hp_in  = 5;
  int   hp_out = 14;
  int   passed = 0;
  int   total  = 0;

  cdc_req_resp_bridge_if bus ();

  cdc_req_resp_bridge dut (
    .clk_in   (clk_in),
    .clk_out  (clk_out),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #(hp_in) clk_in = ~clk_in;
  end

  initial begin
    clk_out = 1'b0;
    #2;
    forever #(hp_out) clk_out = ~clk_out;
  end

  typedef struct {
    logic [31:0] req;
    logic [31:0] rsp;
    logic [31:0] exp_out;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic send_req(input logic [31:0] d, output bit ok);
    @(negedge clk_in);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    @(posedge clk_in);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_out_req(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 50 && !ok) begin
      @(posedge clk_out);
      #1;
      n++;
      ok = bus.out_req_valid;
    end
  endtask

  task automatic accept_out_req();
    bus.out_req_ready = 1'b1;
    @(posedge clk_out);
    #1;
    bus.out_req_ready = 1'b0;
  endtask

  task automatic send_reply(input logic [31:0] d, output bit ok);
    bus.out_rsp_valid = 1'b1;
    bus.out_rsp_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_rsp_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_out);
      #1;
    end
    @(posedge clk_out);
    #1;
    bus.out_rsp_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 50 && !ok) begin
      @(posedge clk_in);
      #1;
      n++;
      ok = bus.rsp_valid;
    end
  endtask

  task automatic take_rsp(output bit rdy_same, output bit rdy_next, output bit vld_after);
    @(negedge clk_in);
    rdy_same      = bus.req_ready;
    bus.rsp_ready = 1'b1;
    @(posedge clk_in);
    #1;
    bus.rsp_ready = 1'b0;
    rdy_next      = bus.req_ready;
    vld_after     = bus.rsp_valid;
  endtask

  // Full checked transaction including latency bounds and the req_ready re-arm timing
  task automatic do_txn(input string tag, input logic [31:0] rq, input logic [31:0] rs,
                        input logic [31:0] exp_out, input logic [31:0] exp_rsp);
    int n;
    bit ok, a, b, c;
    send_req(rq, ok);
    check({tag, "_req_accepted"}, 32'(ok), 32'd1);
    wait_out_req(n, ok);
    check({tag, "_out_req_within_4"}, 32'(ok && n <= 4), 32'd1);
    check({tag, "_out_req_data"}, bus.out_req_data, exp_out);
    accept_out_req();
    check({tag, "_out_rsp_ready"}, 32'(bus.out_rsp_ready), 32'd1);
    send_reply(rs, ok);
    check({tag, "_reply_accepted"}, 32'(ok), 32'd1);
    wait_rsp(n, ok);
    check({tag, "_rsp_within_4"}, 32'(ok && n <= 4), 32'd1);
    check({tag, "_rsp_data"}, bus.rsp_data, exp_rsp);
    take_rsp(a, b, c);
    check({tag, "_req_ready_not_same_cycle"}, 32'(a), 32'd0);
    check({tag, "_req_ready_next_cycle"}, 32'(b), 32'd1);
    check({tag, "_rsp_valid_dropped"}, 32'(c), 32'd0);
  endtask

  initial begin
    int          n, bad, errs, dly;
    bit          ok, a, b, c;
    logic [31:0] rq, rs;
    logic [31:0] exp_q[$];
    int          r_in [3];
    int          r_out[3];

    vecs[0] = '{req: 32'hDEADBEEF, rsp: 32'h12345678, exp_out: 32'hDEADBEEF, exp_rsp: 32'h12345678};
    vecs[1] = '{req: 32'h00000000, rsp: 32'hFFFFFFFF, exp_out: 32'h00000000, exp_rsp: 32'hFFFFFFFF};
    vecs[2] = '{req: 32'hFFFFFFFF, rsp: 32'h00000000, exp_out: 32'hFFFFFFFF, exp_rsp: 32'h00000000};
    vecs[3] = '{req: 32'hAAAAAAAA, rsp: 32'h55555555, exp_out: 32'hAAAAAAAA, exp_rsp: 32'h55555555};
    vecs[4] = '{req: 32'h00000001, rsp: 32'h80000000, exp_out: 32'h00000001, exp_rsp: 32'h80000000};
    r_in  = '{5, 15, 20};
    r_out = '{15, 5, 21};

    reset_in          = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_data      = '0;
    bus.rsp_ready     = 1'b0;
    bus.out_req_ready = 1'b0;
    bus.out_rsp_valid = 1'b0;
    bus.out_rsp_data  = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_out_req_valid", 32'(bus.out_req_valid), 32'd0);
    check("rst_out_rsp_ready", 32'(bus.out_rsp_ready), 32'd0);
    check("rst_out_req_data", bus.out_req_data, 32'd0);
    reset_in = 1'b0;
    repeat (6) @(posedge clk_out);
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Table of single transactions
    for (int i = 0; i < 5; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].rsp, vecs[i].exp_out, vecs[i].exp_rsp);

    // Stall: a second request held during I_WAIT waits for the first response to be consumed
    send_req(32'h11110001, ok);
    check("stall_first_accepted", 32'(ok), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_data  = 32'h000000A5;
    wait_out_req(n, ok);
    check("stall_out_req_seen", 32'(ok), 32'd1);
    check("stall_out_req_data_first", bus.out_req_data, 32'h11110001);
    check("stall_req_ready_low", 32'(bus.req_ready), 32'd0);
    accept_out_req();
    send_reply(32'h00002222, ok);
    wait_rsp(n, ok);
    check("stall_rsp_data", bus.rsp_data, 32'h00002222);
    check("stall_req_ready_low_in_rsp", 32'(bus.req_ready), 32'd0);
    check("stall_out_req_data_kept", bus.out_req_data, 32'h11110001);
    take_rsp(a, b, c);
    check("stall_ready_not_same_cycle", 32'(a), 32'd0);
    check("stall_ready_next_cycle", 32'(b), 32'd1);
    @(posedge clk_in);
    #1;
    bus.req_valid = 1'b0;
    wait_out_req(n, ok);
    check("stall_second_seen", 32'(ok), 32'd1);
    check("stall_second_data", bus.out_req_data, 32'h000000A5);
    accept_out_req();
    send_reply(32'h0000005A, ok);
    wait_rsp(n, ok);
    check("stall_second_rsp", bus.rsp_data, 32'h0000005A);
    take_rsp(a, b, c);

    // Back-pressure on both sides
    send_req(32'hCAFEF00D, ok);
    wait_out_req(n, ok);
    check("bp_out_req_seen", 32'(ok), 32'd1);
    bad = 0;
    repeat (20) begin
      @(posedge clk_out);
      #1;
      if (!bus.out_req_valid || bus.out_req_data !== 32'hCAFEF00D || bus.out_rsp_ready) bad++;
    end
    check("bp_out_req_held", 32'(bad), 32'd0);
    check("bp_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
    accept_out_req();
    send_reply(32'hBEEF0001, ok);
    wait_rsp(n, ok);
    check("bp_rsp_seen", 32'(ok), 32'd1);
    bad = 0;
    repeat (15) begin
      @(negedge clk_in);
      if (!bus.rsp_valid || bus.rsp_data !== 32'hBEEF0001 || bus.req_ready) bad++;
      if (bus.out_req_valid) bad++;
    end
    check("bp_rsp_held", 32'(bad), 32'd0);
    take_rsp(a, b, c);
    check("bp_rsp_consumed", 32'(c), 32'd0);

    // Early reply offered in O_REQ is ignored
    send_req(32'h00000077, ok);
    wait_out_req(n, ok);
    bus.out_rsp_valid = 1'b1;
    bus.out_rsp_data  = 32'h000000FF;
    bad = 0;
    repeat (5) begin
      @(posedge clk_out);
      #1;
      if (bus.out_rsp_ready || !bus.out_req_valid) bad++;
    end
    check("early_reply_ignored", 32'(bad), 32'd0);
    bus.out_rsp_valid = 1'b0;
    check("early_no_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    accept_out_req();
    send_reply(32'h00000001, ok);
    wait_rsp(n, ok);
    check("early_rsp_data", bus.rsp_data, 32'h00000001);
    take_rsp(a, b, c);

    // Reset while the responder sees the request
    send_req(32'h00000033, ok);
    wait_out_req(n, ok);
    check("rstmid_in_o_req", 32'(bus.out_req_valid), 32'd1);
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rstmid_out_req_valid", 32'(bus.out_req_valid), 32'd0);
    check("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
    check("rstmid_out_rsp_ready", 32'(bus.out_rsp_ready), 32'd0);
    reset_in = 1'b0;
    repeat (10) @(posedge clk_out);
    #1;
    check("rstmid_idle_out", 32'(bus.out_req_valid), 32'd0);
    check("rstmid_ready_again", 32'(bus.req_ready), 32'd1);
    do_txn("rstmid_next", 32'h00000005, 32'h00000505, 32'h00000005, 32'h00000505);
    bad = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (bus.rsp_valid || bus.out_req_valid) bad++;
    end
    check("rstmid_single_response", 32'(bad), 32'd0);

    // Random payloads at several clock ratios against a response scoreboard
    for (int r = 0; r < 3; r++) begin
      hp_in  = r_in[r];
      hp_out = r_out[r];
      repeat (4) @(posedge clk_out);
      errs = 0;
      for (int i = 0; i < 200; i++) begin
        rq = $urandom;
        rs = $urandom;
        send_req(rq, ok);
        if (!ok) errs++;
        wait_out_req(n, ok);
        if (!ok || bus.out_req_data !== rq) errs++;
        dly = $urandom_range(0, 2);
        repeat (dly) begin
          @(posedge clk_out);
          #1;
        end
        accept_out_req();
        exp_q.push_back(rs);
        send_reply(rs, ok);
        if (!ok) errs++;
        wait_rsp(n, ok);
        if (!ok || exp_q.size() == 0) errs++;
        else if (bus.rsp_data !== exp_q.pop_front()) errs++;
        dly = $urandom_range(0, 2);
        repeat (dly) @(negedge clk_in);
        take_rsp(a, b, c);
        if (a || !b || c) errs++;
      end
      check($sformatf("stress_ratio%0d_errors", r), 32'(errs), 32'd0);
      check($sformatf("stress_ratio%0d_scoreboard_empty", r), 32'(exp_q.size()), 32'd0);
    end
    repeat (10) @(negedge clk_in);
    check("final_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("final_idle_out_req_valid", 32'(bus.out_req_valid), 32'd0);
    check("final_idle_req_ready", 32'(bus.req_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
